// File: rtl/heap_pq.sv
// Sequential max-heap priority queue: one compare/swap per clock for sift-up
// after a push and sift-down after a pop or replace-top.
module heap_pq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned IW = ADDR_W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]  arr_q [DEPTH];

  logic               idle, push_fire, pop_fire;
  logic               we0, we1;
  logic [ADDR_W-1:0]  wa0, wa1;
  logic [DATA_W-1:0]  wd0, wd1;
  logic [ADDR_W-1:0]  par;
  logic [IW-1:0]      lch, rch, lg;
  logic [DATA_W-1:0]  lg_val;

  assign idle      = (state_q == IDLE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign busy      = !idle;
  assign in_ready  = idle && !full;
  assign out_valid = idle && !empty;
  assign out_data  = empty ? '0 : arr_q[0];
  assign count     = count_q;
  assign push_fire = in_valid && in_ready;
  assign pop_fire  = out_valid && out_ready;

  // Parent / largest-child selection; child indices are wide enough never to wrap.
  always_comb begin
    par    = (idx_q - ADDR_W'(1)) >> 1;
    lch    = (IW'(idx_q) << 1) + IW'(1);
    rch    = lch + IW'(1);
    lg     = IW'(idx_q);
    lg_val = arr_q[idx_q];
    if (lch < IW'(count_q) && arr_q[ADDR_W'(lch)] > lg_val) begin
      lg     = lch;
      lg_val = arr_q[ADDR_W'(lch)];
    end
    if (rch < IW'(count_q) && arr_q[ADDR_W'(rch)] > lg_val) begin
      lg     = rch;
      lg_val = arr_q[ADDR_W'(rch)];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    we0     = 1'b0;
    wa0     = '0;
    wd0     = '0;
    we1     = 1'b0;
    wa1     = '0;
    wd1     = '0;
    case (state_q)
      IDLE: begin
        if (push_fire && pop_fire) begin
          // Replace-top: consumer takes the old root, new key sinks from the top.
          we0   = 1'b1;
          wd0   = in_data;
          idx_d = '0;
          if (count_q > CW'(1)) state_d = SIFT_DOWN;
        end else if (push_fire) begin
          we0     = 1'b1;
          wa0     = ADDR_W'(count_q);
          wd0     = in_data;
          idx_d   = ADDR_W'(count_q);
          count_d = count_q + CW'(1);
          if (count_q != '0) state_d = SIFT_UP;
        end else if (pop_fire) begin
          we0     = 1'b1;
          wd0     = arr_q[ADDR_W'(count_q - CW'(1))];
          count_d = count_q - CW'(1);
          idx_d   = '0;
          if (count_q > CW'(2)) state_d = SIFT_DOWN;
        end
      end
      SIFT_UP: begin
        if (idx_q == '0 || arr_q[par] >= arr_q[idx_q]) begin
          state_d = IDLE;
        end else begin
          we0   = 1'b1;
          wa0   = par;
          wd0   = arr_q[idx_q];
          we1   = 1'b1;
          wa1   = idx_q;
          wd1   = arr_q[par];
          idx_d = par;
        end
      end
      SIFT_DOWN: begin
        if (lg == IW'(idx_q)) begin
          state_d = IDLE;
        end else begin
          we0   = 1'b1;
          wa0   = idx_q;
          wd0   = lg_val;
          we1   = 1'b1;
          wa1   = ADDR_W'(lg);
          wd1   = arr_q[idx_q];
          idx_d = ADDR_W'(lg);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Heap storage is deliberately not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (we0) arr_q[wa0] <= wd0;
    if (we1) arr_q[wa1] <= wd1;
  end

endmodule

// File: tb/tb_heap_pq.sv
// Directed and model-based bench for heap_pq: a 16-entry instance for ordering,
// latency, replace-top and random traffic, and a 4-entry instance for full behaviour.
module tb_heap_pq;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, empty, full, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_empty, s_full, s_busy;
  logic [31:0] s_in_data, s_out_data;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  heap_pq #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .empty(empty), .full(full), .busy(busy)
  );

  heap_pq #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count), .empty(s_empty), .full(s_full), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] key;
    int          exp_busy;
    logic [31:0] exp_root;
  } push_vec_t;

  logic [31:0] mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic push(input logic [31:0] k, output int cyc);
    chk("push_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = k;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic pop(input logic [31:0] exp);
    int c;
    chk("pop_valid", 64'(out_valid), 64'd1);
    chk("pop_data", 64'(out_data), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_idle(c);
  endtask

  task automatic wait_small_idle();
    int c;
    c = 0;
    while (s_busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("small_idle_timeout", 64'(s_busy), 64'd0);
  endtask

  function automatic int model_max_idx();
    int mi;
    mi = 0;
    for (int i = 1; i < mq.size(); i++)
      if (mq[i] > mq[mi]) mi = i;
    return mi;
  endfunction

  initial begin
    push_vec_t   tbl5 [5];
    push_vec_t   asc  [7];
    logic [31:0] drain5 [5];
    int          cyc;
    logic [31:0] key;
    int          sel, mi;

    tbl5[0] = '{32'd5, 0, 32'd5};
    tbl5[1] = '{32'd3, 1, 32'd5};
    tbl5[2] = '{32'd8, 2, 32'd8};
    tbl5[3] = '{32'd1, 1, 32'd8};
    tbl5[4] = '{32'd9, 3, 32'd9};
    drain5  = '{32'd9, 32'd8, 32'd5, 32'd3, 32'd1};
    asc[0]  = '{32'd1, 0, 32'd1};
    asc[1]  = '{32'd2, 2, 32'd2};
    asc[2]  = '{32'd3, 2, 32'd3};
    asc[3]  = '{32'd4, 3, 32'd4};
    asc[4]  = '{32'd5, 3, 32'd5};
    asc[5]  = '{32'd6, 3, 32'd6};
    asc[6]  = '{32'd7, 3, 32'd7};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);

    // Unsorted pushes then sorted drain
    foreach (tbl5[i]) begin
      push(tbl5[i].key, cyc);
      chk("p5_busy", 64'(cyc), 64'(tbl5[i].exp_busy));
      chk("p5_root", 64'(out_data), 64'(tbl5[i].exp_root));
      chk("p5_count", 64'(count), 64'(i + 1));
    end
    foreach (drain5[i]) begin
      pop(drain5[i]);
      chk("d5_count", 64'(count), 64'(4 - i));
    end
    chk("d5_empty", 64'(empty), 64'd1);
    chk("d5_out_data", 64'(out_data), 64'd0);
    chk("d5_out_valid", 64'(out_valid), 64'd0);

    // Ascending pushes: sift-up latency per push
    foreach (asc[i]) begin
      push(asc[i].key, cyc);
      chk("asc_busy", 64'(cyc), 64'(asc[i].exp_busy));
      chk("asc_root", 64'(out_data), 64'(asc[i].exp_root));
    end
    for (int k = 7; k >= 1; k--) pop(32'(k));
    chk("asc_empty", 64'(empty), 64'd1);

    // Replace-top on {10,4,6}
    push(32'd10, cyc); push(32'd4, cyc); push(32'd6, cyc);
    chk("rt_before", 64'(out_data), 64'd10);
    in_valid = 1'b1; in_data = 32'd2; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rt_count", 64'(count), 64'd3);
    wait_idle(cyc);
    chk("rt_root", 64'(out_data), 64'd6);
    pop(32'd6); pop(32'd4); pop(32'd2);

    // Duplicates
    push(32'd7, cyc); push(32'd7, cyc); push(32'd7, cyc);
    chk("dup_count", 64'(count), 64'd3);
    pop(32'd7); pop(32'd7); pop(32'd7);
    chk("dup_empty", 64'(empty), 64'd1);

    // Empty heap: in_valid with out_ready high is a plain push
    in_valid = 1'b1; in_data = 32'd42; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ep_count", 64'(count), 64'd1);
    chk("ep_root", 64'(out_data), 64'd42);
    pop(32'd42);

    // Reset in the middle of a sift-up
    push(32'd10, cyc);
    in_valid = 1'b1; in_data = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_empty", 64'(empty), 64'd1);
    chk("mid_busy0", 64'(busy), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_out_data", 64'(out_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_count", 64'(count), 64'd0);

    // Full behaviour on the 4-entry instance
    for (int k = 1; k <= 4; k++) begin
      s_in_valid = 1'b1; s_in_data = 32'(k);
      @(negedge clk);
      s_in_valid = 1'b0;
      wait_small_idle();
    end
    chk("full_flag", 64'(s_full), 64'd1);
    chk("full_in_ready", 64'(s_in_ready), 64'd0);
    chk("full_root", 64'(s_out_data), 64'd4);
    s_in_valid = 1'b1; s_in_data = 32'd9;
    repeat (3) @(negedge clk);
    chk("full_held", 64'(s_count), 64'd4);
    chk("full_pop_data", 64'(s_out_data), 64'd4);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    chk("full_after_pop", 64'(s_full), 64'd0);
    chk("full_pop_count", 64'(s_count), 64'd3);
    chk("full_pop_busy", 64'(s_busy), 64'd1);
    chk("full_busy_block", 64'(s_in_ready), 64'd0);
    wait_small_idle();
    chk("full_ready_back", 64'(s_in_ready), 64'd1);
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("full_accept", 64'(s_count), 64'd4);
    wait_small_idle();
    chk("full_new_root", 64'(s_out_data), 64'd9);

    // Random traffic against a reference model
    mq.delete();
    for (int n = 0; n < 1000; n++) begin
      chk("rnd_count", 64'(count), 64'(mq.size()));
      if (mq.size() > 0) chk("rnd_max", 64'(out_data), 64'(mq[model_max_idx()]));
      sel = int'($urandom_range(0, 2));
      key = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if (mq.size() == 0 || (sel == 0 && mq.size() < 16)) begin
        push(key, cyc);
        mq.push_back(key);
      end else if (sel == 1 || mq.size() == 16) begin
        mi = model_max_idx();
        pop(mq[mi]);
        mq.delete(mi);
      end else begin
        mi = model_max_idx();
        chk("rnd_rt_data", 64'(out_data), 64'(mq[mi]));
        in_valid = 1'b1; in_data = key; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_idle(cyc);
        mq.delete(mi);
        mq.push_back(key);
      end
    end
    chk("rnd_final_count", 64'(count), 64'(mq.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
